rob_retire_queue: RTL and testbench

Circular reorder buffer that tracks in-flight renamed instructions and produces the in-order retire stream consumed by the architectural map table. It accepts up to C_DP_NUM dispatches and C_CDB_NUM completions per cycle. It retires up to C_RT_NUM completed head entries per cycle and drives the per-lane `ROB_AMT` records (wr_en, arch_reg, phy_reg). It also returns each retired entry's old tag to the free list and asserts rollback when a mispredicted branch retires.

---
 rtl/rob_retire_queue.sv | 166 ++++++++++++++++
 tb/tb_rob_retire_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_retire_queue.sv
// rtl/rob_retire_queue.sv - circular reorder buffer with in-order multi-lane retire to the AMT

package rob_retire_queue_pkg;
    localparam int ROB_ENTRY_NUM = 32;
    localparam int RT_NUM        = 2;
    localparam int MT_ENTRY_NUM  = 32;
    localparam int TAG_IDX_WIDTH = 6;

    typedef struct packed {
        logic                            wr_en;
        logic [$clog2(MT_ENTRY_NUM)-1:0] arch_reg;
        logic [TAG_IDX_WIDTH-1:0]        phy_reg;
    } rob_amt_t;
endpackage

module rob_retire_queue
    import rob_retire_queue_pkg::*;
#(
    parameter int C_ROB_ENTRY_NUM = ROB_ENTRY_NUM,
    parameter int C_DP_NUM        = 2,
    parameter int C_CDB_NUM       = 2,
    parameter int C_RT_NUM        = RT_NUM,
    parameter int C_MT_ENTRY_NUM  = MT_ENTRY_NUM,
    parameter int C_TAG_IDX_WIDTH = TAG_IDX_WIDTH,
    localparam int IW = $clog2(C_ROB_ENTRY_NUM),
    localparam int CW = $clog2(C_ROB_ENTRY_NUM + 1),
    localparam int AW = $clog2(C_MT_ENTRY_NUM),
    localparam int DW = $clog2(C_DP_NUM + 1),
    localparam int RW = $clog2(C_RT_NUM + 1),
    localparam int TW = C_TAG_IDX_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [C_DP_NUM-1:0]           dp_valid_i,
    input  logic [C_DP_NUM-1:0][AW-1:0]   dp_arch_reg_i,
    input  logic [C_DP_NUM-1:0][TW-1:0]   dp_tag_i,
    input  logic [C_DP_NUM-1:0][TW-1:0]   dp_tag_old_i,
    output logic [DW-1:0]                 dp_num_o,
    output logic [C_DP_NUM-1:0][IW-1:0]   dp_rob_idx_o,
    input  logic [C_CDB_NUM-1:0]          cdb_valid_i,
    input  logic [C_CDB_NUM-1:0][IW-1:0]  cdb_rob_idx_i,
    input  logic [C_CDB_NUM-1:0]          cdb_br_mispredict_i,
    output rob_amt_t [C_RT_NUM-1:0]       rob_amt_o,
    output logic [C_RT_NUM-1:0]           fl_valid_o,
    output logic [C_RT_NUM-1:0][TW-1:0]   fl_tag_o,
    output logic                          rollback_o
);

    logic [C_ROB_ENTRY_NUM-1:0] valid_q, complete_q, mispred_q;
    logic [AW-1:0]              arch_q    [C_ROB_ENTRY_NUM];
    logic [TW-1:0]              tag_q     [C_ROB_ENTRY_NUM];
    logic [TW-1:0]              tag_old_q [C_ROB_ENTRY_NUM];
    logic [IW-1:0]              head_q, tail_q;
    logic [CW-1:0]              count_q;

    logic [CW-1:0]              free_cnt;
    logic [DW-1:0]              acc_cnt;
    logic [RW-1:0]              rt_cnt;
    logic [C_RT_NUM-1:0]        rt_lane;
    logic [IW-1:0]              rt_idx    [C_RT_NUM];
    logic                       rt_go;
    logic [C_ROB_ENTRY_NUM-1:0] disp_we, cpl_hit, mp_set, rt_clr;
    logic [C_DP_NUM-1:0]        disp_lane_sel [C_ROB_ENTRY_NUM];

    // Dispatch acceptance is based on registered occupancy only; slots freed by
    // this cycle's retires become visible next cycle.
    always_comb begin
        free_cnt = CW'(C_ROB_ENTRY_NUM) - count_q;
        dp_num_o = (free_cnt >= CW'(C_DP_NUM)) ? DW'(C_DP_NUM) : DW'(free_cnt);
        acc_cnt  = '0;
        for (int k = 0; k < C_DP_NUM; k++) begin
            dp_rob_idx_o[k] = tail_q + IW'(k);
            if (dp_valid_i[k] && (DW'(k) < dp_num_o)) acc_cnt = acc_cnt + DW'(1);
        end
        for (int e = 0; e < C_ROB_ENTRY_NUM; e++) begin
            disp_we[e]       = 1'b0;
            disp_lane_sel[e] = '0;
            for (int k = 0; k < C_DP_NUM; k++) begin
                if (dp_valid_i[k] && (DW'(k) < dp_num_o) && (dp_rob_idx_o[k] == IW'(e))) begin
                    disp_we[e]          = 1'b1;
                    disp_lane_sel[e][k] = 1'b1;
                end
            end
        end
    end

    // Completion per entry: lanes hitting the same entry OR their mispredict flags.
    always_comb begin
        for (int e = 0; e < C_ROB_ENTRY_NUM; e++) begin
            cpl_hit[e] = 1'b0;
            mp_set[e]  = 1'b0;
            for (int c = 0; c < C_CDB_NUM; c++) begin
                if (cdb_valid_i[c] && (cdb_rob_idx_i[c] == IW'(e))) begin
                    cpl_hit[e] = 1'b1;
                    mp_set[e]  = mp_set[e] | cdb_br_mispredict_i[c];
                end
            end
        end
    end

    // In-order retire: a lane retires only behind retiring lanes, and a retiring
    // mispredicted entry blocks everything above it and raises rollback.
    always_comb begin
        rt_go      = 1'b1;
        rt_cnt     = '0;
        rt_lane    = '0;
        rollback_o = 1'b0;
        rt_clr     = '0;
        for (int j = 0; j < C_RT_NUM; j++) begin
            rt_idx[j]    = head_q + IW'(j);
            rob_amt_o[j] = '0;
            fl_tag_o[j]  = '0;
            if (rt_go && valid_q[rt_idx[j]] && complete_q[rt_idx[j]]) begin
                rt_lane[j]            = 1'b1;
                rt_cnt                = rt_cnt + RW'(1);
                rt_clr[rt_idx[j]]     = 1'b1;
                rob_amt_o[j].wr_en    = 1'b1;
                rob_amt_o[j].arch_reg = arch_q[rt_idx[j]];
                rob_amt_o[j].phy_reg  = tag_q[rt_idx[j]];
                fl_tag_o[j]           = tag_old_q[rt_idx[j]];
                if (mispred_q[rt_idx[j]]) begin
                    rollback_o = 1'b1;
                    rt_go      = 1'b0;
                end
            end else begin
                rt_go = 1'b0;
            end
        end
        fl_valid_o = rt_lane;
    end

    // Entry state and pointers; reset beats rollback, rollback discards this
    // cycle's dispatch and completion.
    always_ff @(posedge clk_i) begin
        if (rst_i || rollback_o) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int e = 0; e < C_ROB_ENTRY_NUM; e++) begin
                if (cpl_hit[e] && valid_q[e]) begin
                    complete_q[e] <= 1'b1;
                    mispred_q[e]  <= mp_set[e];
                end
                if (rt_clr[e]) valid_q[e] <= 1'b0;
                if (disp_we[e]) begin
                    valid_q[e]    <= 1'b1;
                    complete_q[e] <= 1'b0;
                    mispred_q[e]  <= 1'b0;
                    for (int k = 0; k < C_DP_NUM; k++) begin
                        if (disp_lane_sel[e][k]) begin
                            arch_q[e]    <= dp_arch_reg_i[k];
                            tag_q[e]     <= dp_tag_i[k];
                            tag_old_q[e] <= dp_tag_old_i[k];
                        end
                    end
                end
            end
            head_q  <= head_q + IW'(rt_cnt);
            tail_q  <= tail_q + IW'(acc_cnt);
            count_q <= count_q + CW'(acc_cnt) - CW'(rt_cnt);
        end
    end

endmodule

// File: tb/tb_rob_retire_queue.sv
// tb/tb_rob_retire_queue.sv - randomized self-checking bench for rob_retire_queue

module tb_rob_retire_queue;
    import rob_retire_queue_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           dp_valid;
    logic [1:0][4:0]      dp_arch;
    logic [1:0][5:0]      dp_tag, dp_tag_old;
    logic [1:0]           dp_num;
    logic [1:0][4:0]      dp_rob_idx;
    logic [1:0]           cdb_valid;
    logic [1:0][4:0]      cdb_idx;
    logic [1:0]           cdb_mp;
    rob_amt_t [1:0]       rob_amt;
    logic [1:0]           fl_valid;
    logic [1:0][5:0]      fl_tag;
    logic                 rollback;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0] arch;
        logic [5:0] tag;
        logic [5:0] old;
        bit         cpl;
        bit         mp;
        int         idx;
    } ent_t;

    ent_t q[$];
    int   tail_m = 0;

    rob_retire_queue dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .dp_valid_i          (dp_valid),
        .dp_arch_reg_i       (dp_arch),
        .dp_tag_i            (dp_tag),
        .dp_tag_old_i        (dp_tag_old),
        .dp_num_o            (dp_num),
        .dp_rob_idx_o        (dp_rob_idx),
        .cdb_valid_i         (cdb_valid),
        .cdb_rob_idx_i       (cdb_idx),
        .cdb_br_mispredict_i (cdb_mp),
        .rob_amt_o           (rob_amt),
        .fl_valid_o          (fl_valid),
        .fl_tag_o            (fl_tag),
        .rollback_o          (rollback)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; dp_valid = '0; dp_arch = '0; dp_tag = '0; dp_tag_old = '0;
        cdb_valid = '0; cdb_idx = '0; cdb_mp = '0;
    endtask

    // Compare the DUT against the queue model, then advance the model across one edge.
    task automatic step();
        int  n_exp, nret, acc;
        bit  stop, rb;
        bit  ret [2];
        #1;
        n_exp = (32 - q.size()) < 2 ? (32 - q.size()) : 2;
        check("dp_num", 32'(dp_num), 32'(n_exp));
        for (int k = 0; k < 2; k++)
            check($sformatf("dp_rob_idx%0d", k), 32'(dp_rob_idx[k]), 32'((tail_m + k) % 32));
        nret = 0; stop = 0; rb = 0;
        for (int j = 0; j < 2; j++) begin
            ret[j] = 0;
            if (!stop && j < q.size() && q[j].cpl) begin
                ret[j] = 1;
                nret++;
                if (q[j].mp) begin rb = 1; stop = 1; end
            end else begin
                stop = 1;
            end
            check($sformatf("wr_en%0d", j), 32'(rob_amt[j].wr_en), 32'(ret[j]));
            check($sformatf("fl_valid%0d", j), 32'(fl_valid[j]), 32'(ret[j]));
            check($sformatf("arch%0d", j), 32'(rob_amt[j].arch_reg), ret[j] ? 32'(q[j].arch) : 0);
            check($sformatf("phy%0d", j), 32'(rob_amt[j].phy_reg), ret[j] ? 32'(q[j].tag) : 0);
            if (ret[j]) check($sformatf("fl_tag%0d", j), 32'(fl_tag[j]), 32'(q[j].old));
        end
        check("rollback", 32'(rollback), 32'(rb));
        @(posedge clk);
        if (rst || rb) begin
            q.delete();
            tail_m = 0;
        end else begin
            foreach (q[i]) begin
                bit hit = 0, mpv = 0;
                for (int c = 0; c < 2; c++)
                    if (cdb_valid[c] && int'(cdb_idx[c]) == q[i].idx) begin hit = 1; mpv |= cdb_mp[c]; end
                if (hit) begin q[i].cpl = 1; q[i].mp = mpv; end
            end
            for (int j = 0; j < nret; j++) void'(q.pop_front());
            acc = 0;
            for (int k = 0; k < n_exp; k++) begin
                if (dp_valid[k]) begin
                    ent_t e;
                    e.arch = dp_arch[k]; e.tag = dp_tag[k]; e.old = dp_tag_old[k];
                    e.cpl = 0; e.mp = 0; e.idx = (tail_m + k) % 32;
                    q.push_back(e);
                    acc++;
                end
            end
            tail_m = (tail_m + acc) % 32;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic dispatch2(input int base);
        idle_inputs();
        dp_valid = 2'b11;
        dp_arch[0] = 5'(base);     dp_tag[0] = 6'(base + 1); dp_tag_old[0] = 6'(base + 2);
        dp_arch[1] = 5'(base + 3); dp_tag[1] = 6'(base + 4); dp_tag_old[1] = 6'(base + 5);
        step();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        #1;
        check("rst_dp_num", 32'(dp_num), 2);
        check("rst_idx1", 32'(dp_rob_idx[1]), 1);
        check("rst_wr_en", 32'({rob_amt[1].wr_en, rob_amt[0].wr_en}), 0);

        // Basic dispatch/complete/retire
        idle_inputs();
        dp_valid = 2'b11;
        dp_arch[0] = 5'd3; dp_tag[0] = 6'd40; dp_tag_old[0] = 6'd3;
        dp_arch[1] = 5'd5; dp_tag[1] = 6'd41; dp_tag_old[1] = 6'd5;
        step();
        idle_inputs();
        cdb_valid = 2'b11; cdb_idx[0] = 5'd0; cdb_idx[1] = 5'd1;
        step();
        idle_inputs();
        #1;
        check("t1_wr_en", 32'({rob_amt[1].wr_en, rob_amt[0].wr_en}), 32'b11);
        check("t1_phy0", 32'(rob_amt[0].phy_reg), 40);
        check("t1_phy1", 32'(rob_amt[1].phy_reg), 41);
        check("t1_fl0", 32'(fl_tag[0]), 3);
        check("t1_fl1", 32'(fl_tag[1]), 5);
        step();
        step();

        // Out-of-order completion
        dispatch2(10);
        idle_inputs();
        cdb_valid = 2'b01; cdb_idx[0] = 5'd3;
        step();
        idle_inputs();
        #1;
        check("ooo_none", 32'({rob_amt[1].wr_en, rob_amt[0].wr_en}), 0);
        cdb_valid = 2'b01; cdb_idx[0] = 5'd2;
        step();
        idle_inputs();
        #1;
        check("ooo_both", 32'({rob_amt[1].wr_en, rob_amt[0].wr_en}), 32'b11);
        check("ooo_order", 32'(rob_amt[0].phy_reg), 11);
        step();

        // Fill to full, tail wraps, freed slots appear a cycle late
        do_reset();
        for (int i = 0; i < 16; i++) dispatch2(i);
        idle_inputs();
        #1;
        check("full_dp_num", 32'(dp_num), 0);
        check("full_tail", 32'(dp_rob_idx[0]), 0);
        cdb_valid = 2'b11; cdb_idx[0] = 5'd0; cdb_idx[1] = 5'd1;
        step();
        idle_inputs();
        #1;
        check("full_ret_dp_num", 32'(dp_num), 0);
        step();
        #1;
        check("after_ret_dp_num", 32'(dp_num), 2);

        // Mispredict rollback with same-cycle dispatch dropped
        do_reset();
        dispatch2(20);
        idle_inputs();
        cdb_valid = 2'b11; cdb_idx[0] = 5'd0; cdb_idx[1] = 5'd1; cdb_mp = 2'b01;
        step();
        dispatch2(30);
        #1;
        check("rb_after", 32'(rollback), 0);
        check("rb_tail", 32'(dp_rob_idx[0]), 0);
        check("rb_empty", 32'({rob_amt[1].wr_en, rob_amt[0].wr_en}), 0);

        // Reset mid-stream with 10 entries
        do_reset();
        for (int i = 0; i < 5; i++) dispatch2(i * 6);
        dp_valid = 2'b11;
        cdb_valid = 2'b11; cdb_idx[0] = 5'd0; cdb_idx[1] = 5'd1;
        rst = 1'b1;
        step();
        idle_inputs();
        #1;
        check("mrst_dp_num", 32'(dp_num), 2);
        check("mrst_idx0", 32'(dp_rob_idx[0]), 0);
        check("mrst_idx1", 32'(dp_rob_idx[1]), 1);
        check("mrst_wr_en", 32'({rob_amt[1].wr_en, rob_amt[0].wr_en}), 0);

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int nd;
            idle_inputs();
            nd = $urandom_range(0, 2);
            dp_valid = (nd == 0) ? 2'b00 : (nd == 1) ? 2'b01 : 2'b11;
            for (int k = 0; k < 2; k++) begin
                dp_arch[k] = 5'($urandom); dp_tag[k] = 6'($urandom); dp_tag_old[k] = 6'($urandom);
                cdb_valid[k] = ($urandom_range(0, 3) != 0);
                if (q.size() > 0 && $urandom_range(0, 3) != 0)
                    cdb_idx[k] = 5'(q[$urandom_range(0, q.size() - 1)].idx);
                else
                    cdb_idx[k] = 5'($urandom);
                cdb_mp[k] = ($urandom_range(0, 15) == 0);
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
